fifo_access_ctrl: RTL and testbench

Sequencing and sharing controller for the coregen standard-mode FIFO (1-cycle read latency, active-high rst, full/empty flags).
- Runs the FIFO reset/settle sequence after board reset.
- Arbitrates the FIFO write port round-robin between two valid/ready requesters.
- Turns the FIFO read port into a valid/ready stream through a 2-entry output buffer.
- Sits between the push-button/stimulus logic and the fifo instance in the top level.

---
 rtl/fifo_access_ctrl.sv | 96 +++++++++
 tb/tb_fifo_access_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: FIFO init sequencer, round-robin write arbiter and 2-entry valid/ready read buffer
module fifo_access_ctrl #(
    parameter int DATA_WIDTH  = 4,
    parameter int RST_CYCLES  = 8,
    parameter int WAIT_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  fifo_rst,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_full,
    input  logic                  fifo_empty
);
    localparam int MAXC = RST_CYCLES > WAIT_CYCLES ? RST_CYCLES : WAIT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {S_RST, S_WAIT, S_RUN} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  run, grant0, grant1, pop, pending, last_grant;
    logic [1:0]            count, tail, occ;
    logic [DATA_WIDTH-1:0] buf_q [2];

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= S_RST;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        if (state == S_RST && cnt == CW'(RST_CYCLES - 1)) begin
            state_nx = S_WAIT;
            cnt_nx   = '0;
        end else if (state == S_WAIT && cnt == CW'(WAIT_CYCLES - 1)) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
        end else if (state == S_RUN) begin
            cnt_nx   = '0;
        end
    end

    always_comb begin
        run        = state == S_RUN;
        busy       = !run;
        fifo_rst   = state == S_RST;
        // last_grant=1 means requester 1 won last, so requester 0 wins a tie
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = run && !fifo_full && grant0;
        req1_ready = run && !fifo_full && grant1;
        fifo_wr_en = req0_ready || req1_ready;
        fifo_din   = grant0 ? req0_data : grant1 ? req1_data : '0;
        out_valid  = count != 2'd0;
        out_data   = buf_q[0];
        pop        = out_valid && out_ready;
        tail       = count - {1'b0, pop};
        occ        = tail + {1'b0, pending};
        fifo_rd_en = run && !fifo_empty && occ < 2'd2;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            last_grant <= 1'b1;
            pending    <= 1'b0;
            count      <= 2'd0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            pending    <= fifo_rd_en;
            last_grant <= fifo_wr_en ? req1_ready : last_grant;
            count      <= occ;
            buf_q[0]   <= pending && tail == 2'd0 ? fifo_dout : pop ? buf_q[1] : buf_q[0];
            buf_q[1]   <= pending && tail == 2'd1 ? fifo_dout : buf_q[1];
        end
    end
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// tb_fifo_access_ctrl: vector table, hand sequences and randomized model check for fifo_access_ctrl
module tb_fifo_access_ctrl;
    localparam int DW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, out_valid, busy, fifo_rst;
    logic          fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
    logic [DW-1:0] out_data, fifo_din;
    logic [DW-1:0] fifo_dout = '0;

    always #5 clk = ~clk;

    fifo_access_ctrl #(.DATA_WIDTH(DW), .RST_CYCLES(8), .WAIT_CYCLES(8)) dut (
        .clk(clk), .res_n(res_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .fifo_rst(fifo_rst), .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    // standard-mode FIFO stand-in; ovr forces the flags for directed cases
    logic [DW-1:0] fq[$];
    int            fsize = 0;
    logic          ovr = 1'b0, ovr_full = 1'b0, ovr_empty = 1'b0;
    assign fifo_full  = ovr ? ovr_full  : (fsize >= DEPTH);
    assign fifo_empty = ovr ? ovr_empty : (fsize == 0);

    always @(posedge clk) begin
        if (fifo_rst) fq.delete();
        else begin
            if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (fifo_wr_en && fq.size() < DEPTH) fq.push_back(fifo_din);
        end
        fsize <= fq.size();
    end

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_fifo_rst"}, fifo_rst, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_wr_en"}, fifo_wr_en, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    task automatic do_reset();
        res_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0; ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1 res_n = 1'b1;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // entered with res_n low; cycle 0 is the period in which res_n rises
    task automatic init_check(input string tag);
        req0_valid = 1'b1; req0_data = 4'hA;
        @(posedge clk);
        #1 res_n = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            chk({tag, "_fifo_rst"}, fifo_rst, k < 8);
            chk({tag, "_busy"}, busy, k < 16);
            chk({tag, "_wr_en"}, fifo_wr_en, k == 16);
            chk({tag, "_rd_en"}, fifo_rd_en, 0);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0;
    endtask

    logic [DW-1:0] wv [4] = '{4'h3, 4'h5, 4'h7, 4'h9};

    task automatic write_words();
        ovr = 1'b1; ovr_empty = 1'b1; ovr_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_data = wv[i];
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
    endtask

    typedef struct {
        logic          r0v;
        logic [DW-1:0] r0d;
        logic          r1v;
        logic [DW-1:0] r1d;
        logic          full;
        logic          e0;
        logic          e1;
        logic [DW-1:0] edin;
    } vec_t;

    vec_t tv [11];

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got[$];
    logic          m_last, prev_rd, g0, g1, e0, e1, e_valid, e_pop, e_rd;
    int            drawn, n;

    initial begin
        tv[0]  = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 4'h1};
        tv[1]  = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 4'h2};
        tv[2]  = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 4'h1};
        tv[3]  = '{1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'h5};
        tv[4]  = '{1'b0, 4'h0, 1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'h6};
        tv[5]  = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
        tv[6]  = '{1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h3};
        tv[7]  = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0};
        tv[8]  = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 4'h2};
        tv[9]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0};
        tv[10] = '{1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 4'h1};

        #2;
        reset_vals("rst");
        init_check("init");

        // arbitration table; reads held off so only the write port moves
        do_reset();
        ovr = 1'b1; ovr_empty = 1'b1;
        for (int i = 0; i < 11; i++) begin
            req0_valid = tv[i].r0v; req0_data = tv[i].r0d;
            req1_valid = tv[i].r1v; req1_data = tv[i].r1d;
            ovr_full   = tv[i].full;
            @(negedge clk);
            chk($sformatf("vec%0d_ready0", i), req0_ready, tv[i].e0);
            chk($sformatf("vec%0d_ready1", i), req1_ready, tv[i].e1);
            chk($sformatf("vec%0d_wr_en", i), fifo_wr_en, tv[i].e0 | tv[i].e1);
            chk($sformatf("vec%0d_rd_en", i), fifo_rd_en, 0);
            if (tv[i].e0 || tv[i].e1 || (!tv[i].r0v && !tv[i].r1v))
                chk($sformatf("vec%0d_din", i), fifo_din, tv[i].edin);
            @(posedge clk);
            #1;
        end

        // read stream with consumer always ready
        do_reset();
        write_words();
        ovr = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("stream_rd_c%0d", c), fifo_rd_en, c < 4);
            chk($sformatf("stream_valid_c%0d", c), out_valid, c >= 2 && c < 6);
            if (c >= 2 && c < 6) chk($sformatf("stream_data_c%0d", c), out_data, wv[c-2]);
        end

        // output stall then drain
        do_reset();
        write_words();
        ovr = 1'b0; out_ready = 1'b0; n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(fifo_rd_en);
        end
        chk("stall_rd_count", n, 2);
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, wv[0]);
        @(posedge clk);
        #1 out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) got.push_back(out_data);
        end
        chk("drain_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("drain_word%0d", i), got[i], wv[i]);

        // reset while a word is buffered and a read is in flight
        do_reset();
        write_words();
        ovr = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_valid_before", out_valid, 1);
        #2 res_n = 1'b0;
        #1 reset_vals("mid");
        @(posedge clk);
        init_check("reinit");

        // randomized traffic against the reference model
        do_reset();
        m_last = 1'b1; prev_rd = 1'b0; drawn = 0; exp_q.delete();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            req0_valid = 1'($urandom_range(0, 1)); req0_data = DW'($urandom);
            req1_valid = 1'($urandom_range(0, 1)); req1_data = DW'($urandom);
            out_ready  = $urandom_range(0, 3) < (i < 1000 ? 1 : 3);
            @(negedge clk);
            g0 = req0_valid && (!req1_valid || m_last);
            g1 = req1_valid && (!req0_valid || !m_last);
            e0 = g0 && !fifo_full;
            e1 = g1 && !fifo_full;
            chk("rnd_ready0", req0_ready, e0);
            chk("rnd_ready1", req1_ready, e1);
            chk("rnd_wr_en", fifo_wr_en, e0 | e1);
            if (e0 | e1) chk("rnd_din", fifo_din, e0 ? req0_data : req1_data);
            e_valid = (drawn - int'(prev_rd)) > 0;
            chk("rnd_out_valid", out_valid, e_valid);
            e_pop = e_valid && out_ready;
            e_rd  = !fifo_empty && (drawn - int'(e_pop)) < 2;
            chk("rnd_rd_en", fifo_rd_en, e_rd);
            if (e_pop && exp_q.size() > 0) begin
                chk("rnd_out_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (e0) begin m_last = 1'b0; exp_q.push_back(req0_data); end
            if (e1) begin m_last = 1'b1; exp_q.push_back(req1_data); end
            drawn   = drawn + int'(e_rd) - int'(e_pop);
            prev_rd = e_rd;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
